// File: rtl/pixel_event_builder.sv
// pixel_event_builder: per-channel trigger/sample/CSA-reset sequencer with
// tagged ADC capture, merged through a round-robin arbiter into one
// valid/ready word stream.

// One analog channel: IDLE -> SAMPLE -> PEND -> CRST -> IDLE.
module pixel_event_channel #(
  parameter int ADCBITS        = 10,
  parameter int TS_BITS        = 24,
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               trig,
  input  logic [1:0]         trig_type,
  input  logic [TS_BITS-1:0] ts,
  input  logic               done,
  input  logic [ADCBITS-1:0] adc,
  input  logic               grant,
  output logic               pend,
  output logic               timeout,
  output logic               sample,
  output logic               csa_reset,
  output logic [TS_BITS-1:0] ts_lat,
  output logic [1:0]         type_lat,
  output logic [ADCBITS-1:0] adc_lat
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(RESET_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SAMPLE, PEND, CRST} state_t;

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [RW-1:0] rcnt;

  // Timeout is combinational so error_count steps on the same edge the channel leaves SAMPLE.
  assign timeout = (state == SAMPLE) && !done && (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign pend    = (state == PEND);

  // Channel sequencer; sample/csa_reset are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CRST;
      rcnt      <= '0;
      tcnt      <= '0;
      sample    <= 1'b0;
      csa_reset <= 1'b1;
      ts_lat    <= '0;
      type_lat  <= '0;
      adc_lat   <= '0;
    end else begin
      case (state)
        IDLE: if (trig) begin
          state    <= SAMPLE;
          sample   <= 1'b1;
          tcnt     <= '0;
          ts_lat   <= ts;
          type_lat <= trig_type;
        end
        SAMPLE: begin
          if (done) begin
            state   <= PEND;
            sample  <= 1'b0;
            adc_lat <= adc;
          end else if (timeout) begin
            state     <= CRST;
            sample    <= 1'b0;
            csa_reset <= 1'b1;
            rcnt      <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        PEND: if (grant) begin
          state     <= CRST;
          csa_reset <= 1'b1;
          rcnt      <= '0;
        end
        CRST: begin
          if (rcnt == RW'(RESET_CYCLES - 1)) begin
            state     <= IDLE;
            csa_reset <= 1'b0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module pixel_event_builder #(
  parameter int NUMCHANNELS    = 64,
  parameter int ADCBITS        = 10,
  parameter int TS_BITS        = 24,
  parameter int RESET_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CHW            = $clog2(NUMCHANNELS),
  parameter int WORDW          = 2 + CHW + TS_BITS + ADCBITS
)(
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUMCHANNELS-1:0]         hit,
  input  logic [NUMCHANNELS-1:0]         done,
  input  logic [ADCBITS*NUMCHANNELS-1:0] dout,
  input  logic                           external_trigger,
  input  logic [NUMCHANNELS-1:0]         channel_enable,
  input  logic                           ext_trig_enable,
  input  logic [TS_BITS-1:0]             periodic_interval,
  output logic [NUMCHANNELS-1:0]         sample,
  output logic [NUMCHANNELS-1:0]         csa_reset,
  output logic [WORDW-1:0]               data_out,
  output logic                           data_valid,
  input  logic                           data_ready,
  output logic [7:0]                     error_count
);
  logic [TS_BITS-1:0] ts, pcnt;
  logic               pulse, ext, load, any_pend;
  logic [1:0]         trig_type;
  logic [CHW-1:0]     last_grant, win;
  int                 idx;
  logic [8:0]         n_to;
  logic [9:0]         err_sum;

  logic [NUMCHANNELS-1:0]              trig, grant, pend, timeout;
  logic [NUMCHANNELS-1:0][TS_BITS-1:0] ts_lat;
  logic [NUMCHANNELS-1:0][1:0]         type_lat;
  logic [NUMCHANNELS-1:0][ADCBITS-1:0] adc_lat;

  assign pulse     = (periodic_interval != '0) && (pcnt == periodic_interval - TS_BITS'(1));
  assign ext       = ext_trig_enable & external_trigger;
  assign trig_type = ext ? 2'b01 : (pulse ? 2'b10 : 2'b00);
  assign load      = !data_valid || data_ready;

  // Free-running timestamp and periodic self-trigger counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts   <= '0;
      pcnt <= '0;
    end else begin
      ts <= ts + TS_BITS'(1);
      if (periodic_interval == '0 || pulse) pcnt <= '0;
      else                                  pcnt <= pcnt + TS_BITS'(1);
    end
  end

  for (genvar i = 0; i < NUMCHANNELS; i++) begin : g_ch
    assign trig[i]  = channel_enable[i] & (hit[i] | ext | pulse);
    assign grant[i] = load & any_pend & (win == CHW'(i));

    pixel_event_channel #(
      .ADCBITS(ADCBITS), .TS_BITS(TS_BITS),
      .RESET_CYCLES(RESET_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_ch (
      .clk(clk), .reset(reset), .trig(trig[i]), .trig_type(trig_type), .ts(ts),
      .done(done[i]), .adc(dout[i*ADCBITS +: ADCBITS]), .grant(grant[i]),
      .pend(pend[i]), .timeout(timeout[i]), .sample(sample[i]), .csa_reset(csa_reset[i]),
      .ts_lat(ts_lat[i]), .type_lat(type_lat[i]), .adc_lat(adc_lat[i])
    );
  end

  // Round-robin pick: first PEND channel scanning upward from last_grant+1.
  always_comb begin
    any_pend = 1'b0;
    win      = '0;
    idx      = 0;
    for (int k = 0; k < NUMCHANNELS; k++) begin
      idx = int'(last_grant) + 1 + k;
      if (idx >= NUMCHANNELS) idx = idx - NUMCHANNELS;
      if (!any_pend && pend[CHW'(idx)]) begin
        any_pend = 1'b1;
        win      = CHW'(idx);
      end
    end
  end

  // Output word register; holds under backpressure, refills every cycle otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_valid <= 1'b0;
      data_out   <= '0;
      last_grant <= CHW'(NUMCHANNELS - 1);
    end else if (load) begin
      data_valid <= any_pend;
      if (any_pend) begin
        data_out   <= {type_lat[win], win, ts_lat[win], adc_lat[win]};
        last_grant <= win;
      end
    end
  end

  // Several channels may time out on the same edge, so add the population count.
  always_comb begin
    n_to = '0;
    for (int i = 0; i < NUMCHANNELS; i++) n_to = n_to + 9'(timeout[i]);
  end
  assign err_sum = 10'(error_count) + 10'(n_to);

  // Saturating timeout counter.
  always_ff @(posedge clk) begin
    if (reset) error_count <= '0;
    else       error_count <= (err_sum > 10'd255) ? 8'hFF : err_sum[7:0];
  end
endmodule

// File: tb/tb_pixel_event_builder.sv
// Directed bench for pixel_event_builder: 4 channels, 4-cycle CSA reset, 8-cycle timeout.
module tb_pixel_event_builder;
  localparam int N = 4, AB = 10, TSB = 24, RC = 4, TO = 8, CHW = 2, WW = 2 + CHW + TSB + AB;

  logic              clk = 1'b0, reset = 1'b1;
  logic [N-1:0]      hit = '0, done = '0, channel_enable = '0;
  logic [AB*N-1:0]   dout = '0;
  logic              external_trigger = 1'b0, ext_trig_enable = 1'b0, data_ready = 1'b1;
  logic [TSB-1:0]    periodic_interval = '0;
  logic [N-1:0]      sample, csa_reset;
  logic [WW-1:0]     data_out;
  logic              data_valid;
  logic [7:0]        error_count;

  int n_run = 0, n_fail = 0;
  int cyc = 0;   // mirrors the expected timestamp value between edges

  pixel_event_builder #(
    .NUMCHANNELS(N), .ADCBITS(AB), .TS_BITS(TSB), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .hit(hit), .done(done), .dout(dout),
    .external_trigger(external_trigger), .channel_enable(channel_enable),
    .ext_trig_enable(ext_trig_enable), .periodic_interval(periodic_interval),
    .sample(sample), .csa_reset(csa_reset), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .error_count(error_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (reset) cyc <= 0; else cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [WW-1:0] mkw(input logic [1:0] t, input int ch, input int ts, input int adc);
    return {t, CHW'(ch), TSB'(ts), AB'(adc)};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_run++; if (csa_reset !== 4'hF) begin n_fail++; $display("FAIL rst_csa: got %b want 1111", csa_reset); end
    n_run++; if (sample !== 4'h0) begin n_fail++; $display("FAIL rst_sample: got %b want 0000", sample); end
    n_run++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", data_valid); end
    n_run++; if (data_out !== '0) begin n_fail++; $display("FAIL rst_data: got %h want 0", data_out); end
    n_run++; if (error_count !== 8'd0) begin n_fail++; $display("FAIL rst_err: got %0d want 0", error_count); end
    reset = 1'b0;
    // csa_reset spans the cycles ending at edges 1..4 after release
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_run++;
      if (csa_reset !== ((i < 4) ? 4'hF : 4'h0)) begin
        n_fail++; $display("FAIL rel_csa[%0d]: got %b want %b", i, csa_reset, (i < 4) ? 4'hF : 4'h0);
      end
    end
  endtask

  task automatic test_external(input int rep);
    int t0, base;
    base = 'h100 + rep * 8;
    channel_enable = 4'hF; ext_trig_enable = 1'b1; external_trigger = 1'b1; t0 = cyc;
    @(negedge clk); external_trigger = 1'b0;
    n_run++; if (sample !== 4'hF) begin n_fail++; $display("FAIL ext_sample%0d: got %b want 1111", rep, sample); end
    for (int i = 0; i < N; i++) dout[i*AB +: AB] = AB'(base + i);
    done = 4'hF;
    @(negedge clk); done = '0;
    n_run++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL ext_pend%0d: got valid %b want 0", rep, data_valid); end
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      n_run++;
      if (data_valid !== 1'b1 || data_out !== mkw(2'b01, i, t0, base + i)) begin
        n_fail++; $display("FAIL ext_word%0d_%0d: got v=%b %h want %h", rep, i, data_valid, data_out, mkw(2'b01, i, t0, base + i));
      end
    end
    @(negedge clk);
    n_run++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL ext_drain%0d: got valid %b want 0", rep, data_valid); end
    repeat (6) @(negedge clk);
    ext_trig_enable = 1'b0;
  endtask

  task automatic test_natural();
    int g, hi;
    g = 0;
    while (cyc != 100 && g < 500) begin @(negedge clk); g++; end
    n_run++; if (cyc != 100) begin n_fail++; $display("FAIL nat_wait: cyc %0d want 100", cyc); end
    channel_enable = 4'hF; hit = 4'b0100;
    @(negedge clk); hit = '0;
    n_run++; if (sample !== 4'b0100) begin n_fail++; $display("FAIL nat_sample: got %b want 0100", sample); end
    repeat (3) @(negedge clk);
    dout[2*AB +: AB] = 10'h2A5; done = 4'b0100;
    @(negedge clk); done = '0;
    n_run++; if (sample !== 4'b0000) begin n_fail++; $display("FAIL nat_sample_off: got %b want 0000", sample); end
    @(negedge clk);
    n_run++;
    if (data_valid !== 1'b1 || data_out !== mkw(2'b00, 2, 100, 'h2A5)) begin
      n_fail++; $display("FAIL nat_word: got v=%b %h want %h", data_valid, data_out, mkw(2'b00, 2, 100, 'h2A5));
    end
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      if (csa_reset[2]) hi++;
      if (i == 1) begin
        n_run++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL nat_single: got valid %b want 0", data_valid); end
      end
      @(negedge clk);
    end
    n_run++; if (hi != RC) begin n_fail++; $display("FAIL nat_csa_len: got %0d want %0d", hi, RC); end
  endtask

  task automatic test_periodic();
    int t0, g, hi;
    channel_enable = 4'b0010; t0 = cyc; periodic_interval = 16;
    for (int j = 0; j < 3; j++) begin
      g = 0;
      while (!sample[1] && g < 40) begin @(negedge clk); g++; end
      n_run++; if (sample[1] !== 1'b1) begin n_fail++; $display("FAIL per_trig%0d: no sample after %0d cycles", j, g); end
      repeat (2) @(negedge clk);
      dout[1*AB +: AB] = AB'('h050 + j); done = 4'b0010;
      @(negedge clk); done = '0;
      @(negedge clk);
      n_run++;
      if (data_valid !== 1'b1 || data_out !== mkw(2'b10, 1, t0 + 15 + 16 * j, 'h050 + j)) begin
        n_fail++; $display("FAIL per_word%0d: got v=%b %h want %h", j, data_valid, data_out, mkw(2'b10, 1, t0 + 15 + 16 * j, 'h050 + j));
      end
    end
    periodic_interval = 0;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sample[1]) hi++;
    end
    n_run++; if (hi != 0) begin n_fail++; $display("FAIL per_stop: %0d sample cycles want 0", hi); end
  endtask

  task automatic test_backpressure();
    int t0, bad_d, bad_c;
    channel_enable = 4'hF; data_ready = 1'b0; t0 = cyc; hit = 4'b0111;
    @(negedge clk); hit = '0;
    dout[0 +: AB] = 10'h011; dout[AB +: AB] = 10'h022; dout[2*AB +: AB] = 10'h033; done = 4'b0111;
    @(negedge clk); done = '0;
    @(negedge clk);
    // last_grant is 1 here, so ch2 is picked first, then ch0, ch1
    n_run++;
    if (data_valid !== 1'b1 || data_out !== mkw(2'b00, 2, t0, 'h033)) begin
      n_fail++; $display("FAIL bp_first: got v=%b %h want %h", data_valid, data_out, mkw(2'b00, 2, t0, 'h033));
    end
    bad_d = 0; bad_c = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (data_valid !== 1'b1 || data_out !== mkw(2'b00, 2, t0, 'h033)) bad_d++;
      if (csa_reset[1:0] !== 2'b00 || sample !== 4'h0) bad_c++;
    end
    n_run++; if (bad_d != 0) begin n_fail++; $display("FAIL bp_stable: %0d unstable cycles want 0", bad_d); end
    n_run++; if (bad_c != 0) begin n_fail++; $display("FAIL bp_pend_hold: %0d csa/sample cycles want 0", bad_c); end
    data_ready = 1'b1;
    @(negedge clk);
    n_run++;
    if (data_valid !== 1'b1 || data_out !== mkw(2'b00, 0, t0, 'h011)) begin
      n_fail++; $display("FAIL bp_drain0: got v=%b %h want %h", data_valid, data_out, mkw(2'b00, 0, t0, 'h011));
    end
    n_run++; if (csa_reset !== 4'b0001) begin n_fail++; $display("FAIL bp_csa0: got %b want 0001", csa_reset); end
    @(negedge clk);
    n_run++;
    if (data_valid !== 1'b1 || data_out !== mkw(2'b00, 1, t0, 'h022)) begin
      n_fail++; $display("FAIL bp_drain1: got v=%b %h want %h", data_valid, data_out, mkw(2'b00, 1, t0, 'h022));
    end
    @(negedge clk);
    n_run++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got valid %b want 0", data_valid); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_timeout();
    int bad;
    channel_enable = 4'b1000; hit = 4'b1000;
    @(negedge clk); hit = '0;
    bad = 0;
    repeat (TO - 1) begin
      @(negedge clk);
      if (data_valid !== 1'b0) bad++;
    end
    n_run++; if (sample !== 4'b1000) begin n_fail++; $display("FAIL to_wait_sample: got %b want 1000", sample); end
    n_run++; if (error_count !== 8'd0) begin n_fail++; $display("FAIL to_early_err: got %0d want 0", error_count); end
    @(negedge clk);
    n_run++; if (csa_reset !== 4'b1000 || sample !== 4'b0000) begin
      n_fail++; $display("FAIL to_fire: got csa=%b sample=%b want 1000/0000", csa_reset, sample);
    end
    n_run++; if (error_count !== 8'd1) begin n_fail++; $display("FAIL to_err1: got %0d want 1", error_count); end
    n_run++; if (bad != 0 || data_valid !== 1'b0) begin n_fail++; $display("FAIL to_noword: %0d valid cycles want 0", bad); end
    // level hit retriggers every 13 cycles (1 + 8 + 4); well over 255 timeouts
    hit = 4'b1000;
    repeat (13 * 300) @(negedge clk);
    hit = '0;
    n_run++; if (error_count !== 8'd255) begin n_fail++; $display("FAIL to_sat: got %0d want 255", error_count); end
    repeat (14) @(negedge clk);
  endtask

  task automatic test_midreset();
    int bad;
    channel_enable = 4'b0001; data_ready = 1'b0; hit = 4'b0001;
    @(negedge clk); hit = '0;
    dout[0 +: AB] = 10'h155; done = 4'b0001;
    @(negedge clk); done = '0;
    @(negedge clk);
    n_run++; if (data_valid !== 1'b1 || data_out[AB-1:0] !== 10'h155) begin
      n_fail++; $display("FAIL mr_pre: got v=%b adc=%h want 1/155", data_valid, data_out[AB-1:0]);
    end
    reset = 1'b1;
    @(negedge clk);
    n_run++; if (data_valid !== 1'b0 || data_out !== '0) begin
      n_fail++; $display("FAIL mr_clear: got v=%b %h want 0/0", data_valid, data_out);
    end
    n_run++; if (error_count !== 8'd0) begin n_fail++; $display("FAIL mr_err: got %0d want 0", error_count); end
    n_run++; if (csa_reset !== 4'hF) begin n_fail++; $display("FAIL mr_csa: got %b want 1111", csa_reset); end
    reset = 1'b0; data_ready = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (data_valid !== 1'b0) bad++;
    end
    n_run++; if (bad != 0) begin n_fail++; $display("FAIL mr_discard: %0d valid cycles want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_external(0);
    test_external(1);
    test_natural();
    test_periodic();
    test_backpressure();
    test_timeout();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
